ex_stage: RTL and testbench

Execute stage that consumes the ID/EX pipeline register outputs and produces the values the EX/MEM register captures. It contains the forwarding muxes from EX/MEM and MEM/WB, a single-cycle ALU, and an iterative shift-add multiplier. While a multiply is in flight, the multiplier stalls the front of the pipeline and injects bubbles downstream.

---
 rtl/ex_stage.sv | 164 ++++++++++++++++
 tb/tb_ex_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage between the ID/EX and EX/MEM pipeline registers.
// It holds the EX/MEM and MEM/WB forwarding muxes, a single-cycle ALU and an
// iterative shift-add multiplier that stalls the front of the pipeline.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   exData1/exData2       register-file read data from ID/EX
//   exRs/exRt/exRd        source and destination register numbers
//   exOffset, exAluSel    immediate and its operand-B select
//   exAluOp               ALU operation (110 = multi-cycle MUL)
//   exRegDst              write-register select (1: exRd, 0: exRt)
//   exRegWrite/exMemWrite/exMemRead/exMemToReg  control from ID/EX
//   exmem*/memwb*         later-stage write-back info used for forwarding
//   aluResult, storeData, writeReg              datapath results to EX/MEM
//   regWriteOut/memWriteOut/memReadOut          controls, forced to 0 while busy
//   memToRegOut           exMemToReg passed through
//   busy                  hold request for PC, IF/ID and ID/EX
module ex_stage #(
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exData1,
  input  logic [31:0] exData2,
  input  logic [4:0]  exRs,
  input  logic [4:0]  exRt,
  input  logic [4:0]  exRd,
  input  logic [15:0] exOffset,
  input  logic [2:0]  exAluOp,
  input  logic        exAluSel,
  input  logic        exRegDst,
  input  logic        exRegWrite,
  input  logic        exMemWrite,
  input  logic        exMemRead,
  input  logic        exMemToReg,
  input  logic        exmemRegWrite,
  input  logic [4:0]  exmemRd,
  input  logic [31:0] exmemAluResult,
  input  logic        memwbRegWrite,
  input  logic [4:0]  memwbRd,
  input  logic [31:0] memwbWriteData,
  output logic [31:0] aluResult,
  output logic [31:0] storeData,
  output logic [4:0]  writeReg,
  output logic        regWriteOut,
  output logic        memWriteOut,
  output logic        memReadOut,
  output logic        memToRegOut,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(MUL_ITERS);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]   mplier;
  logic [DATA_W-1:0]   product;

  logic [DATA_W-1:0]   fwd_a;
  logic [DATA_W-1:0]   fwd_b;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   alu_c;
  logic                issue;

  // Forwarding muxes; EX/MEM wins over MEM/WB, register 0 is never forwarded.
  always_comb begin
    fwd_a = exData1;
    if (exmemRegWrite && (exmemRd != 5'd0) && (exmemRd == exRs))
      fwd_a = exmemAluResult;
    else if (memwbRegWrite && (memwbRd != 5'd0) && (memwbRd == exRs))
      fwd_a = memwbWriteData;

    fwd_b = exData2;
    if (exmemRegWrite && (exmemRd != 5'd0) && (exmemRd == exRt))
      fwd_b = exmemAluResult;
    else if (memwbRegWrite && (memwbRd != 5'd0) && (memwbRd == exRt))
      fwd_b = memwbWriteData;
  end

  assign op_b = exAluSel ? {{16{exOffset[15]}}, exOffset} : fwd_b;

  // Single-cycle ALU; MUL reports the product register, reserved 111 adds.
  always_comb begin
    alu_c = fwd_a + op_b;
    case (exAluOp)
      OP_ADD:  alu_c = fwd_a + op_b;
      OP_SUB:  alu_c = fwd_a - op_b;
      OP_AND:  alu_c = fwd_a & op_b;
      OP_OR:   alu_c = fwd_a | op_b;
      OP_SLT:  alu_c = ($signed(fwd_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      OP_XOR:  alu_c = fwd_a ^ op_b;
      OP_MUL:  alu_c = product;
      default: alu_c = fwd_a + op_b;
    endcase
  end

  // A MUL seen in IDLE is the issue cycle and already counts as a stall cycle.
  assign issue = (state == IDLE) && (exAluOp == OP_MUL);

  // Multiplier sequencer: operands are latched at issue so forwarding
  // sources draining during the stall cannot disturb the running multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            mcand   <= fwd_a;
            mplier  <= op_b;
            product <= '0;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (mplier[0])
            product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MUL_ITERS - 1))
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces busy low even if a MUL is sitting on the inputs.
  assign busy = !rst && (issue || (state == BUSY));

  always_comb begin
    aluResult   = (state == DONE) ? product : alu_c;
    storeData   = fwd_b;
    writeReg    = exRegDst ? exRd : exRt;
    regWriteOut = exRegWrite && !busy;
    memWriteOut = exMemWrite && !busy;
    memReadOut  = exMemRead && !busy;
    memToRegOut = exMemToReg;
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exData1, exData2;
  logic [4:0]  exRs, exRt, exRd;
  logic [15:0] exOffset;
  logic [2:0]  exAluOp;
  logic        exAluSel, exRegDst, exRegWrite, exMemWrite, exMemRead, exMemToReg;
  logic        exmemRegWrite;
  logic [4:0]  exmemRd;
  logic [31:0] exmemAluResult;
  logic        memwbRegWrite;
  logic [4:0]  memwbRd;
  logic [31:0] memwbWriteData;
  logic [31:0] aluResult, storeData;
  logic [4:0]  writeReg;
  logic        regWriteOut, memWriteOut, memReadOut, memToRegOut, busy;

  int total = 0;
  int bad   = 0;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .exData1(exData1), .exData2(exData2),
    .exRs(exRs), .exRt(exRt), .exRd(exRd),
    .exOffset(exOffset), .exAluOp(exAluOp), .exAluSel(exAluSel),
    .exRegDst(exRegDst), .exRegWrite(exRegWrite), .exMemWrite(exMemWrite),
    .exMemRead(exMemRead), .exMemToReg(exMemToReg),
    .exmemRegWrite(exmemRegWrite), .exmemRd(exmemRd), .exmemAluResult(exmemAluResult),
    .memwbRegWrite(memwbRegWrite), .memwbRd(memwbRd), .memwbWriteData(memwbWriteData),
    .aluResult(aluResult), .storeData(storeData), .writeReg(writeReg),
    .regWriteOut(regWriteOut), .memWriteOut(memWriteOut), .memReadOut(memReadOut),
    .memToRegOut(memToRegOut), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic no_hazard();
    exmemRegWrite = 1'b0; exmemRd = 5'd0; exmemAluResult = 32'h0;
    memwbRegWrite = 1'b0; memwbRd = 5'd0; memwbWriteData = 32'h0;
  endtask

  // Counts busy cycles starting at the current sample point, then checks DONE.
  task automatic run_mul(input string tag, input logic [31:0] exp, input bit disturb);
    int n;
    bit gated;
    n = 0;
    gated = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      if (regWriteOut !== 1'b0 || memWriteOut !== 1'b0 || memReadOut !== 1'b0)
        gated = 1'b0;
      if (disturb && n == 10) begin
        exmemRegWrite = 1'b1; exmemRd = exRs; exmemAluResult = 32'hDEAD_BEEF;
        memwbRegWrite = 1'b1; memwbRd = exRt; memwbWriteData = 32'h0000_1234;
        exData1 = 32'h7; exData2 = 32'h9;
      end
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
    chk({tag, "_gated"}, {31'd0, gated}, 32'd1);
    chk({tag, "_result"}, aluResult, exp);
    chk({tag, "_done_regwrite"}, {31'd0, regWriteOut}, 32'd1);
    chk({tag, "_done_memread"}, {31'd0, memReadOut}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    exData1 = 32'd0; exData2 = 32'd0; exRs = 5'd0; exRt = 5'd0; exRd = 5'd0;
    exOffset = 16'd0; exAluOp = 3'b000; exAluSel = 1'b0; exRegDst = 1'b0;
    exRegWrite = 1'b1; exMemWrite = 1'b0; exMemRead = 1'b0; exMemToReg = 1'b1;
    no_hazard();
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_alu", aluResult, 32'd0);
    chk("reset_memtoreg", {31'd0, memToRegOut}, 32'd1);

    // ADD with no hazard, R-type destination
    @(negedge clk); rst = 1'b0;
    exData1 = 32'd5; exData2 = 32'd7; exRs = 5'd1; exRt = 5'd2; exRd = 5'd9;
    exRegDst = 1'b1; exAluOp = 3'b000;
    #1;
    chk("add", aluResult, 32'd12);
    chk("add_busy", {31'd0, busy}, 32'd0);
    chk("writereg_rd", {27'd0, writeReg}, 32'd9);
    chk("add_regwrite", {31'd0, regWriteOut}, 32'd1);
    exRegDst = 1'b0; #1;
    chk("writereg_rt", {27'd0, writeReg}, 32'd2);

    // Other ALU ops
    @(negedge clk);
    exData1 = 32'd5; exData2 = 32'd7; exAluOp = 3'b001; #1;
    chk("sub_wrap", aluResult, 32'hFFFF_FFFE);
    exData1 = 32'hF0F0_1234; exData2 = 32'h0FF0_FF00; exAluOp = 3'b010; #1;
    chk("and", aluResult, 32'h00F0_1200);
    exAluOp = 3'b101; #1;
    chk("xor", aluResult, 32'hFF00_ED34);
    exData1 = 32'hFFFF_FFFF; exData2 = 32'd1; exAluOp = 3'b100; #1;
    chk("slt_neg", aluResult, 32'd1);
    exData1 = 32'd3; exData2 = 32'hFFFF_FFFF; #1;
    chk("slt_pos", aluResult, 32'd0);
    exData1 = 32'd10; exData2 = 32'd20; exAluOp = 3'b111; #1;
    chk("reserved_add", aluResult, 32'd30);

    // Forwarding priority on operand A
    @(negedge clk);
    exRs = 5'd3; exRt = 5'd4; exData1 = 32'h11; exData2 = 32'd0; exAluOp = 3'b011;
    exmemRegWrite = 1'b1; exmemRd = 5'd3; exmemAluResult = 32'hAA;
    memwbRegWrite = 1'b1; memwbRd = 5'd3; memwbWriteData = 32'hBB;
    #1;
    chk("fwd_exmem_prio", aluResult, 32'hAA);
    exmemRd = 5'd0; #1;
    chk("fwd_memwb", aluResult, 32'hBB);
    // Register 0 is never forwarded
    exRs = 5'd0; memwbRd = 5'd0; exmemRd = 5'd0; #1;
    chk("fwd_reg0", aluResult, 32'h11);
    // Operand B forwarding shows up on storeData
    exRt = 5'd7; memwbRd = 5'd7; memwbWriteData = 32'h55; #1;
    chk("fwd_b_store", storeData, 32'h55);

    // Sign-extended immediate; storeData still shows forwarded B
    @(negedge clk);
    no_hazard();
    exRs = 5'd1; exRt = 5'd2; exData1 = 32'd1; exData2 = 32'h1234;
    exOffset = 16'hFFFF; exAluSel = 1'b1; exAluOp = 3'b000;
    #1;
    chk("imm_add", aluResult, 32'd0);
    chk("imm_store", storeData, 32'h1234);

    // MUL with forwarded values disturbed mid-stall
    @(negedge clk);
    exAluSel = 1'b0; exData1 = 32'h0001_0003; exData2 = 32'h0000_0005;
    exRegWrite = 1'b1; exMemWrite = 1'b1; exMemRead = 1'b1; exAluOp = 3'b110;
    #1;
    chk("mul1_issue_busy", {31'd0, busy}, 32'd1);
    run_mul("mul1", 32'h0005_000F, 1'b1);
    chk("mul1_done_memwrite", {31'd0, memWriteOut}, 32'd1);

    // Wrap-around MUL, then a held second MUL back to back
    @(negedge clk);
    no_hazard();
    exData1 = 32'hFFFF_FFFF; exData2 = 32'd2; exAluOp = 3'b110;
    #1;
    run_mul("mul2", 32'hFFFF_FFFE, 1'b0);
    @(negedge clk); #1;
    chk("b2b_reissue", {31'd0, busy}, 32'd1);
    run_mul("mul3", 32'hFFFF_FFFE, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clk);
    exData1 = 32'd6; exData2 = 32'd7; exAluOp = 3'b110;
    #1;
    chk("rst_issue_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    #1;
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_regwrite", {31'd0, regWriteOut}, 32'd1);
    @(negedge clk);
    rst = 1'b0; exAluOp = 3'b000; exData1 = 32'd2; exData2 = 32'd3;
    #1;
    chk("post_rst_add", aluResult, 32'd5);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    chk("post_rst_add2", aluResult, 32'd5);
    chk("post_rst_busy2", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
